lif_update_unit: RTL and testbench



---
 rtl/snn_pkg.sv | 46 ++++
 rtl/lif_neuron_core.sv | 73 +++++++
 rtl/lif_update_unit.sv | 191 +++++++++++++++++++
 tb/tb_lif_update_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//   Shared types and helpers for the spiking-neuron datapath.
//
//   lif_state_t : state encoding of the serial LIF update controller
//   W_SUM       : signed width of one synaptic sum word from the adder stage
//   W_V         : signed width of a stored membrane potential
//   W_ACC       : working width of the integrate arithmetic (W_V + 2 bits)
//   saturate()  : clamps a W_ACC-bit signed value into the W_V-bit range
// ---------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } lif_state_t;

    localparam int W_SUM = 16;
    localparam int W_V   = 16;

    // Two guard bits are enough for V - leak + sum: each of the three terms
    // lies inside the W_V (or W_SUM <= W_V) range, so the result cannot
    // overflow W_V + 2 bits.
    localparam int W_ACC = W_V + 2;

    localparam logic signed [W_ACC-1:0] ACC_V_MAX = W_ACC'((1 << (W_V - 1)) - 1);
    // Bitwise inverse of the positive limit is exactly -2^(W_V-1).
    localparam logic signed [W_ACC-1:0] ACC_V_MIN = ~ACC_V_MAX;

    // Clamp to the representable potential range instead of wrapping, so a
    // strongly inhibited neuron can never flip to a large positive value.
    function automatic logic signed [W_V-1:0] saturate(input logic signed [W_ACC-1:0] x);
        logic signed [W_V-1:0] r;
        if (x > ACC_V_MAX) begin
            r = ACC_V_MAX[W_V-1:0];
        end else if (x < ACC_V_MIN) begin
            r = ACC_V_MIN[W_V-1:0];
        end else begin
            r = x[W_V-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// ---------------------------------------------------------------------------
// lif_neuron_core
//   Purely combinational leaky integrate-and-fire update for one neuron.
//   Shared by the serial update unit and the parallel LIF variant.
//
//   Ports:
//     v         in   W_V     current membrane potential (signed)
//     refr      in   W_REFR  current refractory counter
//     sum       in   W_SUM   synaptic sum for this step (signed)
//     v_next    out  W_V     potential to store back
//     refr_next out  W_REFR  refractory counter to store back
//     spike     out  1       neuron fires this step
//
//   Rules:
//     refr > 0   : count down, hold V at V_RESET, no spike, sum ignored
//     otherwise  : V_new = sat(V - (V >>> LEAK_SHIFT) + sum)
//                  V_new >= V_TH fires: V <- V_RESET, refr <- T_REF
// ---------------------------------------------------------------------------
module lif_neuron_core
    import snn_pkg::*;
#(
    parameter int V_TH       = 1000,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int T_REF      = 2,
    parameter int W_REFR     = 2
) (
    input  logic signed [W_V-1:0]   v,
    input  logic        [W_REFR-1:0] refr,
    input  logic signed [W_SUM-1:0] sum,
    output logic signed [W_V-1:0]   v_next,
    output logic        [W_REFR-1:0] refr_next,
    output logic                    spike
);

    localparam logic signed [W_V-1:0]  V_TH_W    = W_V'(V_TH);
    localparam logic signed [W_V-1:0]  V_RESET_W = W_V'(V_RESET);
    localparam logic        [W_REFR-1:0] T_REF_W = W_REFR'(T_REF);
    localparam logic        [W_REFR-1:0] ONE_R   = W_REFR'(1);

    logic signed [W_V-1:0]   leak;
    logic signed [W_ACC-1:0] v_ext;
    logic signed [W_ACC-1:0] leak_ext;
    logic signed [W_ACC-1:0] sum_ext;
    logic signed [W_ACC-1:0] acc;
    logic signed [W_V-1:0]   v_sat;

    always_comb begin
        // Arithmetic shift keeps the leak pulling negative potentials
        // back toward zero as well (floor division by 2^LEAK_SHIFT).
        leak     = v >>> LEAK_SHIFT;
        v_ext    = {{(W_ACC - W_V){v[W_V-1]}}, v};
        leak_ext = {{(W_ACC - W_V){leak[W_V-1]}}, leak};
        sum_ext  = {{(W_ACC - W_SUM){sum[W_SUM-1]}}, sum};
        acc      = v_ext - leak_ext + sum_ext;
        v_sat    = saturate(acc);
    end

    always_comb begin
        v_next    = v_sat;
        refr_next = refr;
        spike     = 1'b0;
        if (refr != '0) begin
            refr_next = refr - ONE_R;
            v_next    = V_RESET_W;
        end else if (v_sat >= V_TH_W) begin
            spike     = 1'b1;
            v_next    = V_RESET_W;
            refr_next = T_REF_W;
        end
    end

endmodule

// File: rtl/lif_update_unit.sv
// ---------------------------------------------------------------------------
// lif_update_unit
//   Serial LIF stage: on each lif_en request it walks the N_NEURON synaptic
//   sums, updates the stored potentials and refractory counters through
//   lif_neuron_core and publishes the resulting spike vector.
//
//   Ports:
//     clk        in   1          clock
//     rst        in   1          synchronous active-high reset
//     lif_en     in   1          step request from the controller
//     mem_clr    in   1          clear all V and refractory counters (IDLE only)
//     sum_addr   out  IDX_W      read address into the adder sum buffer
//     sum_rd     out  1          read strobe; sum_data valid the next cycle
//     sum_data   in   W_SUM      signed synaptic sum
//     spike_vec  out  N_NEURON   spikes of the last step, bit i = neuron i
//     lif_ready  out  1          step complete
//     v_mon      out  W_V        potential of the neuron last written
//
//   Handshake: lif_en is a level request that the controller holds until it
//   sees lif_ready. lif_ready is registered and stays high for as long as
//   lif_en stays high; lif_en falling closes the transaction and returns the
//   unit to IDLE. A new step needs lif_en to fall and rise again. lif_en
//   falling before completion aborts the step without raising lif_ready.
//
//   Sequence per step: FETCH(idx) / UPDATE(idx) pairs for idx = 0..N-1,
//   then DONE. The sum buffer has one cycle of read latency, so the address
//   issued in FETCH is consumed in the following UPDATE.
// ---------------------------------------------------------------------------
module lif_update_unit
    import snn_pkg::*;
#(
    parameter int N_NEURON   = 4,
    parameter int V_TH       = 1000,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int T_REF      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lif_en,
    input  logic                         mem_clr,
    output logic [$clog2(N_NEURON)-1:0]  sum_addr,
    output logic                         sum_rd,
    input  logic signed [W_SUM-1:0]      sum_data,
    output logic [N_NEURON-1:0]          spike_vec,
    output logic                         lif_ready,
    output logic signed [W_V-1:0]        v_mon
);

    localparam int IDX_W  = $clog2(N_NEURON);
    localparam int W_REFR = $clog2(T_REF + 1);

    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(N_NEURON - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1);
    localparam logic signed [W_V-1:0]  V_RESET_W = W_V'(V_RESET);

    // Controller state is kept in a plainly named register so checkers can
    // bind to it directly.
    lif_state_t state_q;
    lif_state_t state_d;

    logic [IDX_W-1:0]        idx_q;
    logic signed [W_V-1:0]   v_mem    [N_NEURON];
    logic [W_REFR-1:0]       refr_mem [N_NEURON];

    logic                    step_start;
    logic                    clr_all;
    logic                    do_write;
    logic                    idx_last;

    logic signed [W_V-1:0]   core_v_next;
    logic [W_REFR-1:0]       core_refr_next;
    logic                    core_spike;

    // -----------------------------------------------------------------------
    // Next-state and strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        step_start = 1'b0;
        clr_all    = 1'b0;
        do_write   = 1'b0;
        idx_last   = (idx_q == IDX_LAST);

        case (state_q)
            IDLE: begin
                if (lif_en) begin
                    state_d    = FETCH;
                    step_start = 1'b1;
                end else if (mem_clr) begin
                    clr_all = 1'b1;
                end
            end
            FETCH: begin
                state_d = lif_en ? UPDATE : IDLE;
            end
            UPDATE: begin
                if (!lif_en) begin
                    state_d = IDLE;
                end else begin
                    do_write = 1'b1;
                    state_d  = idx_last ? DONE : FETCH;
                end
            end
            DONE: begin
                if (!lif_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sum buffer read port: the address follows the neuron index, the strobe
    // is high for the single FETCH cycle of each neuron.
    // -----------------------------------------------------------------------
    assign sum_addr = idx_q;
    assign sum_rd   = (state_q == FETCH);

    // -----------------------------------------------------------------------
    // Per-neuron arithmetic
    // -----------------------------------------------------------------------
    lif_neuron_core #(
        .V_TH       (V_TH),
        .V_RESET    (V_RESET),
        .LEAK_SHIFT (LEAK_SHIFT),
        .T_REF      (T_REF),
        .W_REFR     (W_REFR)
    ) u_core (
        .v         (v_mem[idx_q]),
        .refr      (refr_mem[idx_q]),
        .sum       (sum_data),
        .v_next    (core_v_next),
        .refr_next (core_refr_next),
        .spike     (core_spike)
    );

    // -----------------------------------------------------------------------
    // Neuron state, index, spike vector and handshake output
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            spike_vec <= '0;
            lif_ready <= 1'b0;
            v_mon     <= '0;
            for (int i = 0; i < N_NEURON; i++) begin
                v_mem[i]    <= V_RESET_W;
                refr_mem[i] <= '0;
            end
        end else begin
            if (step_start) begin
                idx_q     <= '0;
                spike_vec <= '0;
            end

            if (clr_all) begin
                for (int i = 0; i < N_NEURON; i++) begin
                    v_mem[i]    <= V_RESET_W;
                    refr_mem[i] <= '0;
                end
            end

            if (do_write) begin
                v_mem[idx_q]     <= core_v_next;
                refr_mem[idx_q]  <= core_refr_next;
                spike_vec[idx_q] <= core_spike;
                v_mon            <= core_v_next;
                if (!idx_last) begin
                    idx_q <= idx_q + IDX_ONE;
                end
            end

            // Registered in DONE, so it rises one cycle after the last write
            // and falls on the same edge that leaves DONE.
            lif_ready <= (state_q == DONE) && lif_en;
        end
    end

endmodule

// File: tb/tb_lif_update_unit.sv
// ---------------------------------------------------------------------------
// tb_lif_update_unit
//   Directed and randomized steps against a plain-integer model of the LIF
//   rules. A small responder models the adder sum buffer (one cycle read
//   latency); expected spike vectors flow through exp_q.
// ---------------------------------------------------------------------------
module tb_lif_update_unit;

  localparam int N = 4;
  localparam int LAT = 2 * N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              lif_en;
  logic              mem_clr;
  logic [1:0]        sum_addr;
  logic              sum_rd;
  logic signed [15:0] sum_data = '0;
  logic [N-1:0]      spike_vec;
  logic              lif_ready;
  logic signed [15:0] v_mon;

  lif_update_unit dut (
    .clk       (clk),
    .rst       (rst),
    .lif_en    (lif_en),
    .mem_clr   (mem_clr),
    .sum_addr  (sum_addr),
    .sum_rd    (sum_rd),
    .sum_data  (sum_data),
    .spike_vec (spike_vec),
    .lif_ready (lif_ready),
    .v_mon     (v_mon)
  );

  // ---------------- sum buffer responder ----------------
  int sums [N];
  int rd_cnt = 0;

  // Sampled mid-cycle: FETCH lasts one full cycle, so each read is seen once.
  always @(negedge clk) begin
    if (sum_rd === 1'b1) begin
      sum_data <= 16'(sums[sum_addr]);
      rd_cnt   <= rd_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  int mv [N];
  int mr [N];
  int last_v;

  function automatic logic [N-1:0] model_step(input int n_upd);
    logic [N-1:0] sp;
    sp = '0;
    for (int i = 0; i < n_upd; i++) begin
      if (mr[i] > 0) begin
        mr[i] = mr[i] - 1;
        mv[i] = 0;
      end else begin
        int nv;
        nv = mv[i] - (mv[i] >>> 4) + sums[i];
        if (nv > 32767) nv = 32767;
        if (nv < -32768) nv = -32768;
        if (nv >= 1000) begin
          sp[i] = 1'b1;
          mv[i] = 0;
          mr[i] = 2;
        end else begin
          mv[i] = nv;
        end
      end
      last_v = mv[i];
    end
    return sp;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mr[i] = 0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q [$];
  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_v(input string tag);
    for (int i = 0; i < N; i++) begin
      logic signed [31:0] obs;
      obs = $signed(dut.v_mem[i]);
      check($sformatf("%s_v%0d", tag, i), obs, mv[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  bit clr_during = 1'b0;

  task automatic do_step(input string tag, input int hold);
    int cyc;
    int rd_base;
    int bad;
    bit seen;
    exp_q.push_back(model_step(N));
    rd_base = rd_cnt;
    @(negedge clk);
    lif_en = 1'b1;
    if (clr_during) mem_clr = 1'b1;
    @(posedge clk);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (lif_ready === 1'b1) seen = 1'b1;
    end
    mem_clr = 1'b0;
    check({tag, "_latency"}, seen ? cyc : -1, LAT);
    check({tag, "_spike_vec"}, spike_vec, exp_q.pop_front());
    check_all_v(tag);
    check({tag, "_v_mon"}, v_mon, last_v);
    if (hold > 0) begin
      bad = 0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        if (lif_ready !== 1'b1) bad++;
      end
      check({tag, "_hold_ready_drops"}, bad, 0);
    end
    @(negedge clk);
    check({tag, "_rd_pulses"}, rd_cnt - rd_base, N);
    lif_en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ready_low"}, lif_ready, 0);
  endtask

  task automatic set_sums(input int s0, input int s1, input int s2, input int s3);
    sums[0] = s0;
    sums[1] = s1;
    sums[2] = s2;
    sums[3] = s3;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd_base;
    int bad;
    logic [N-1:0] sp;

    rst = 1'b1;
    lif_en = 1'b0;
    mem_clr = 1'b0;
    set_sums(0, 0, 0, 0);
    model_clear();
    last_v = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_spike_vec", spike_vec, 0);
    check("rst_lif_ready", lif_ready, 0);
    check("rst_sum_rd", sum_rd, 0);
    check("rst_sum_addr", sum_addr, 0);
    check("rst_v_mon", v_mon, 0);
    check_all_v("rst");
    @(negedge clk);
    rst = 1'b0;

    // Step 1: one neuron crosses threshold from rest
    set_sums(200, 0, -100, 1200);
    do_step("step1", 0);

    // Steps 2-4: leak on 0/2, neuron 3 refractory for two steps
    set_sums(0, 0, 0, 2000);
    do_step("step2", 0);
    do_step("step3", 0);
    do_step("step4", 0);

    // Saturation toward the negative rail
    set_sums(-32768, 0, 0, 0);
    do_step("sat1", 0);
    do_step("sat2", 0);
    do_step("sat3", 0);

    // Positive saturation on a non-firing path is impossible (threshold is
    // far below the rail), so drive a large positive sum for the fire path.
    set_sums(32767, 5, -5, 900);
    do_step("big_pos", 0);

    // Hold lif_en long after completion: no re-run
    set_sums(10, 20, 30, 40);
    do_step("hold", 20);

    // Abort in the third FETCH
    set_sums(300, -300, 700, 700);
    sp = model_step(2);
    exp_q.push_back(sp);
    rd_base = rd_cnt;
    @(negedge clk);
    lif_en = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    lif_en = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (lif_ready !== 1'b0) bad++;
    end
    check("abort_ready_seen", bad, 0);
    check("abort_spike_vec", spike_vec, exp_q.pop_front());
    check("abort_rd_pulses", rd_cnt - rd_base, 3);
    check("abort_v_mon", v_mon, last_v);
    check_all_v("abort");

    // Make neuron 0 refractory, then mem_clr must clear V and counters
    set_sums(1500, 100, 100, 100);
    do_step("pre_clr", 0);
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    model_clear();
    check_all_v("mem_clr");
    do_step("post_clr", 0);

    // mem_clr held through a step is ignored outside IDLE
    clr_during = 1'b1;
    set_sums(50, 60, 70, 80);
    do_step("clr_busy", 0);
    clr_during = 1'b0;

    // Randomized steps
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0)
          sums[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        else
          sums[i] = int'($urandom_range(0, 3000)) - 1500;
      end
      do_step($sformatf("rand%0d", r), 0);
    end

    // Reset in the middle of a step
    set_sums(900, 900, 900, 900);
    @(negedge clk);
    lif_en = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    lif_en = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    last_v = 0;
    check("midrst_spike_vec", spike_vec, 0);
    check("midrst_lif_ready", lif_ready, 0);
    check("midrst_sum_rd", sum_rd, 0);
    check("midrst_v_mon", v_mon, 0);
    check_all_v("midrst");
    @(negedge clk);
    rst = 1'b0;
    set_sums(400, 1100, -50, 0);
    do_step("after_rst", 0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
